and_popcount_acc: RTL and testbench

Downstream consumer of the parameterized bitwise-AND stage: takes each N-bit AND result as a beat over a valid/ready handshake, counts its set bits, and accumulates the counts over a fixed frame of FRAME_LEN beats. At frame end it presents the frame total on an output handshake and holds it until consumed. It reduces the AND stage's per-vector match masks to one match score per frame, for the scoring and report logic.

---
 rtl/and_popcount_acc.sv | 130 +++++++++++++
 tb/tb_and_popcount_acc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/and_popcount_acc.sv
`default_nettype none
// ============================================================================
// Module   : and_popcount_acc
// Purpose  : Counts set bits of each accepted AND-stage beat and presents the
//            saturated per-frame total on a valid/ready output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module and_popcount_acc #(
    parameter int N         = 5,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N-1:0]                   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CNT_W-1:0]               out_sum,
    output logic                           out_sat,
    output logic [$clog2(FRAME_LEN+1)-1:0] beat_cnt
);

    localparam int c_pc_w = $clog2(N + 1);
    localparam int c_bc_w = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  c_max  = '1;
    localparam logic [c_bc_w-1:0] c_last = c_bc_w'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_acc;
    logic                r_sat;
    logic [c_bc_w-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]    r_out_sum;
    logic                r_out_sat;
    logic [c_pc_w-1:0]   w_pop;
    logic [CNT_W:0]      w_sum;
    logic                w_over;
    logic [CNT_W-1:0]    w_acc_next;
    logic                w_accept;
    logic                w_last;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + c_pc_w'(in_data[i]);
        end
    end

    // One guard bit above the accumulator exposes overflow for the clamp.
    assign w_sum      = {1'b0, r_acc} + (CNT_W + 1)'(w_pop);
    assign w_over     = w_sum[CNT_W];
    assign w_acc_next = w_over ? c_max : w_sum[CNT_W-1:0];
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_beat_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_ACCUM;
                end
            end
            default: w_state_next = ST_ACCUM;
        endcase
        if (clr) begin
            w_state_next = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_beat_cnt <= '0;
            r_out_sum  <= '0;
            r_out_sat  <= 1'b0;
        end else if (clr) begin
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_beat_cnt <= '0;
            r_out_sum  <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                // Final beat: publish the total including this beat, restart.
                r_out_sum  <= w_acc_next;
                r_out_sat  <= r_sat | w_over;
                r_acc      <= '0;
                r_sat      <= 1'b0;
                r_beat_cnt <= '0;
            end else begin
                r_acc      <= w_acc_next;
                r_sat      <= r_sat | w_over;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign out_sum  = r_out_sum;
    assign out_sat  = r_out_sat;
    assign beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_and_popcount_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_and_popcount_acc
// Purpose  : Self-checking bench for and_popcount_acc against a frame-level
//            reference model (directed scenarios plus randomized traffic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_and_popcount_acc;

    localparam int N     = 5;
    localparam int FL    = 4;
    localparam int CW    = 4;
    localparam int BCW   = $clog2(FL + 1);
    localparam int MAXV  = (1 << CW) - 1;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           clr       = 1'b0;
    logic           in_valid  = 1'b0;
    logic [N-1:0]   in_data   = '0;
    logic           out_ready = 1'b0;
    logic           in_ready;
    logic           out_valid;
    logic [CW-1:0]  out_sum;
    logic           out_sat;
    logic [BCW-1:0] beat_cnt;

    logic           clr1       = 1'b0;
    logic           in_valid1  = 1'b0;
    logic [N-1:0]   in_data1   = '0;
    logic           out_ready1 = 1'b1;
    logic           in_ready1;
    logic           out_valid1;
    logic [7:0]     out_sum1;
    logic           out_sat1;
    logic [0:0]     beat_cnt1;

    and_popcount_acc #(.N(N), .FRAME_LEN(FL), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_sat(out_sat), .beat_cnt(beat_cnt)
    );

    and_popcount_acc #(.N(N), .FRAME_LEN(1), .CNT_W(8)) u_dut_f1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_sat(out_sat1), .beat_cnt(beat_cnt1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame-level view of the block.
    bit m_hold;
    int m_cnt;
    int m_tot;
    int e_sum;
    bit e_sat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b0;
        m_cnt  = 0;
        m_tot  = 0;
        e_sum  = 0;
        e_sat  = 1'b0;
    endtask

    task automatic check_outputs();
        check("in_ready",  32'(in_ready),  32'(!m_hold));
        check("out_valid", 32'(out_valid), 32'(m_hold));
        check("beat_cnt",  32'(beat_cnt),  32'(m_cnt));
        check("out_sum",   32'(out_sum),   32'(e_sum));
        check("out_sat",   32'(out_sat),   32'(e_sat));
    endtask

    task automatic step(input bit v, input logic [N-1:0] d, input bit ordy, input bit c);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else if (!m_hold) begin
            if (v) begin
                m_cnt++;
                m_tot += $countones(d);
                if (m_cnt == FL) begin
                    e_sum  = (m_tot > MAXV) ? MAXV : m_tot;
                    e_sat  = (m_tot > MAXV);
                    m_hold = 1'b1;
                    m_cnt  = 0;
                    m_tot  = 0;
                end
            end
        end else if (ordy) begin
            m_hold = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_reset();
        in_valid = 1'b0;
        clr      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // Basic frame: 1+3+0+1 = 5
        step(1, 5'b00010, 1, 0);
        step(1, 5'b01110, 1, 0);
        step(1, 5'b00000, 1, 0);
        step(1, 5'b10000, 1, 0);
        check("basic_sum", 32'(out_sum), 32'd5);
        check("basic_valid", 32'(out_valid), 32'd1);
        step(0, 5'b00000, 1, 0);
        check("basic_pulse_end", 32'(out_valid), 32'd0);

        // Back-pressure: hold for 6 cycles while a beat is offered
        step(1, 5'b00010, 0, 0);
        step(1, 5'b01110, 0, 0);
        step(1, 5'b00000, 0, 0);
        step(1, 5'b10000, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 5'b11111, 0, 0);
            check("bp_sum", 32'(out_sum), 32'd5);
        end
        step(1, 5'b11111, 1, 0);
        check("bp_no_extra_beat", 32'(beat_cnt), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 5'b00100, 1, 0);
        check("bp_next_sum", 32'(out_sum), 32'd4);
        step(0, 5'b00000, 1, 0);

        // Asynchronous reset mid-frame
        step(1, 5'b11111, 1, 0);
        step(1, 5'b11111, 1, 0);
        async_reset();
        for (int i = 0; i < 4; i++) step(1, 5'b00001, 1, 0);
        check("post_reset_sum", 32'(out_sum), 32'd4);
        step(0, 5'b00000, 1, 0);

        // Saturation at CNT_W=4
        for (int i = 0; i < 4; i++) step(1, 5'b11111, 1, 0);
        check("sat_sum", 32'(out_sum), 32'd15);
        check("sat_flag", 32'(out_sat), 32'd1);
        step(0, 5'b00000, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 5'b00001, 1, 0);
        check("unsat_sum", 32'(out_sum), 32'd4);
        check("unsat_flag", 32'(out_sat), 32'd0);
        step(0, 5'b00000, 1, 0);

        // clr with a valid 4th beat
        for (int i = 0; i < 3; i++) step(1, 5'b11111, 1, 0);
        step(1, 5'b11111, 1, 1);
        check("clr_no_valid", 32'(out_valid), 32'd0);
        step(0, 5'b00000, 1, 0);
        check("clr_no_valid2", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 5'b00011, 1, 0);
        check("clr_next_sum", 32'(out_sum), 32'd8);
        step(0, 5'b00000, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, N'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
        end

        // Reset while in HOLD
        for (int i = 0; i < 4; i++) step(1, N'($urandom), 0, 0);
        async_reset();
        step(0, 5'b00000, 1, 0);

        // FRAME_LEN=1 instance: results 3 then 4
        check("f1_ready0", 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1;
        in_data1  = 5'b10110;
        @(negedge clk);
        check("f1_ready1", 32'(in_ready1), 32'd0);
        check("f1_valid1", 32'(out_valid1), 32'd1);
        check("f1_sum1", 32'(out_sum1), 32'd3);
        in_data1 = 5'b01111;
        @(negedge clk);
        check("f1_ready2", 32'(in_ready1), 32'd1);
        check("f1_valid2", 32'(out_valid1), 32'd0);
        @(negedge clk);
        check("f1_ready3", 32'(in_ready1), 32'd0);
        check("f1_valid3", 32'(out_valid1), 32'd1);
        check("f1_sum2", 32'(out_sum1), 32'd4);
        in_valid1 = 1'b0;
        @(negedge clk);
        check("f1_valid4", 32'(out_valid1), 32'd0);
        check("f1_ready4", 32'(in_ready1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
